bubble_led_driver: RTL and testbench

- Status-indicator stage downstream of the timing generator and SPI loader.
- Consumes ACCTYPE, CURRPAGE and the boot-wait strobe.
- Drives four discrete status LEDs and a 3-digit multiplexed 7-segment display showing the current bubble page.
- Runs in the MCLK domain and holds all display state internally, so display updates never stall the data path.

---
 rtl/bubble_led_driver_if.sv | 23 ++
 rtl/bubble_led_driver.sv | 200 ++++++++++++++++++++
 tb/tb_bubble_led_driver.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bubble_led_driver_if.sv
// Handshake bundle between the bubble controller side and the status LED / 7-segment driver.
// The master drives access type, page and wait strobe; the slave returns the active-low LED and display lines.
interface bubble_led_driver_if;
  logic        nwait;
  logic [2:0]  acctype;
  logic [11:0] currpage;
  logic        naccled;
  logic        nwaitled;
  logic        nreadled;
  logic        nwriteled;
  logic [7:0]  nfnd;
  logic [2:0]  nanode;

  modport master (
    output nwait, acctype, currpage,
    input  naccled, nwaitled, nreadled, nwriteled, nfnd, nanode
  );

  modport slave (
    input  nwait, acctype, currpage,
    output naccled, nwaitled, nreadled, nwriteled, nfnd, nanode
  );
endinterface

// File: rtl/bubble_led_driver.sv
// Status LEDs with tick-based stretch plus a 3-digit multiplexed display of the current bubble page.
// Define BUBBLE_LED_DECIMAL_EN to show the page in decimal via a sequential double-dabble converter.
module bubble_led_driver #(
  parameter int TICK_DIV   = 48000,
  parameter int SCAN_TICKS = 1,
  parameter int HOLD_TICKS = 50
) (
  input logic clk,
  input logic rst,
  bubble_led_driver_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  logic [PW-1:0] presc;
  logic [SW-1:0] scan;
  logic [1:0]    idx;
  logic [HW-1:0] rd_cnt, wr_cnt;
  logic          nwait_q;
  logic [11:0]   disp;
  logic [2:0]    nanode_q;
  logic [7:0]    nfnd_q;

  logic          tick, scan_wrap, frame_wrap;
  logic          read_act, write_act;
  logic          rd_led_n, wr_led_n, acc_n;
  logic [3:0]    nib;
  logic [2:0]    anode_sel;
  logic [6:0]    seg_body;
  logic          dp_sel;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  assign tick       = (presc == PW'(TICK_DIV - 1));
  assign scan_wrap  = tick && (scan == SW'(SCAN_TICKS - 1));
  assign frame_wrap = scan_wrap && (idx == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      scan  <= '0;
      idx   <= 2'd0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (scan_wrap) begin
        scan <= '0;
        idx  <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else if (tick) begin
        scan <= scan + 1'b1;
      end
    end
  end

  // 3'b011 is decoded as a page read, so everything non-idle except 010 lights the read LED.
  assign read_act  = !bus.acctype[2] && (bus.acctype[1:0] != 2'b10);
  assign write_act = (bus.acctype == 3'b010);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      nwait_q <= 1'b1;
    end else begin
      nwait_q <= bus.nwait;
      if (read_act)                    rd_cnt <= HW'(HOLD_TICKS);
      else if (tick && rd_cnt != '0)   rd_cnt <= rd_cnt - 1'b1;
      if (write_act)                   wr_cnt <= HW'(HOLD_TICKS);
      else if (tick && wr_cnt != '0)   wr_cnt <= wr_cnt - 1'b1;
    end
  end

  assign rd_led_n      = (rd_cnt == '0);
  assign wr_led_n      = (wr_cnt == '0);
  assign acc_n         = rd_led_n & wr_led_n;
  assign bus.nreadled  = rd_led_n;
  assign bus.nwriteled = wr_led_n;
  assign bus.naccled   = acc_n;
  assign bus.nwaitled  = nwait_q;

`ifdef BUBBLE_LED_DECIMAL_EN
  typedef enum logic {CV_IDLE, CV_SHIFT} cv_state_t;

  cv_state_t   cv_state, cv_next;
  logic [11:0] sr, bcd, bcd_next;
  logic [3:0]  cv_cnt;
  logic        shift_en, load_disp;

  function automatic logic [11:0] dd_adj(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cv_state <= CV_IDLE;
    else     cv_state <= cv_next;
  end

  // A fresh capture always restarts the conversion, even mid-shift.
  always_comb begin
    cv_next = cv_state;
    if (frame_wrap)
      cv_next = CV_SHIFT;
    else if (cv_state == CV_SHIFT && cv_cnt == 4'd11)
      cv_next = CV_IDLE;
  end

  always_comb begin
    shift_en  = (cv_state == CV_SHIFT);
    load_disp = (cv_state == CV_SHIFT) && (cv_cnt == 4'd11);
  end

  assign bcd_next = {dd_adj(bcd)[10:0], sr[11]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= '0;
      bcd    <= '0;
      cv_cnt <= '0;
    end else if (frame_wrap) begin
      sr     <= (bus.currpage > 12'd999) ? 12'd999 : bus.currpage;
      bcd    <= '0;
      cv_cnt <= '0;
    end else if (shift_en) begin
      sr     <= {sr[10:0], 1'b0};
      bcd    <= bcd_next;
      cv_cnt <= cv_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            disp <= '0;
    else if (load_disp) disp <= bcd_next;
  end
`else
  // Capturing only at the 2->0 wrap keeps a whole frame consistent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             disp <= '0;
    else if (frame_wrap) disp <= bus.currpage;
  end
`endif

  always_comb begin
    nib       = disp[3:0];
    anode_sel = 3'b110;
    case (idx)
      2'd1: begin
        nib       = disp[7:4];
        anode_sel = 3'b101;
      end
      2'd2: begin
        nib       = disp[11:8];
        anode_sel = 3'b011;
      end
      default: ;
    endcase
  end

  assign seg_body = nwait_q ? seg7(nib) : 7'b1111110;
  assign dp_sel   = ~((idx == 2'd0) & ~acc_n);

  // Anode and segments load on the same edge, so a digit never shows its neighbour's pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nanode_q <= 3'b111;
      nfnd_q   <= 8'hFF;
    end else if (scan_wrap) begin
      nanode_q <= anode_sel;
      nfnd_q   <= {seg_body, dp_sel};
    end
  end

  assign bus.nanode = nanode_q;
  assign bus.nfnd   = nfnd_q;

endmodule

// File: tb/tb_bubble_led_driver.sv
// Directed self-checking bench for bubble_led_driver with a fast tick (4 clocks) and short hold (3 ticks).
module tb_bubble_led_driver;
  localparam int TICK_DIV   = 4;
  localparam int SCAN_TICKS = 1;
  localparam int HOLD_TICKS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bubble_led_driver_if bus ();

  bubble_led_driver #(
    .TICK_DIV  (TICK_DIV),
    .SCAN_TICKS(SCAN_TICKS),
    .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic wait_anode(input logic [2:0] pat, output bit found);
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.nanode === pat) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit f;
    rst = 1'b1;
    bus.nwait = 1'b1;
    bus.acctype = 3'b100;
    bus.currpage = 12'h000;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.naccled, bus.nwaitled, bus.nreadled, bus.nwriteled, bus.nfnd, bus.nanode} !== 15'h7FFF) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 7fff",
               {bus.naccled, bus.nwaitled, bus.nreadled, bus.nwriteled, bus.nfnd, bus.nanode});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.nanode !== 3'b111) begin
      errors++;
      $display("[TB] FAIL first_anode_early: got %b expected 111", bus.nanode);
    end
    @(negedge clk);
    checks++;
    if (bus.nanode !== 3'b110 || bus.nfnd !== 8'b0000_0011) begin
      errors++;
      $display("[TB] FAIL first_anode: got %b/%b expected 110/00000011", bus.nanode, bus.nfnd);
    end
    // get some state moving, then reset between clock edges
    bus.acctype = 3'b001;
    @(negedge clk);
    bus.acctype = 3'b100;
    f = 1'b1;
    checks++;
    if (bus.naccled !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pre_reset_acc: got %b expected 0", bus.naccled);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.naccled, bus.nwaitled, bus.nreadled, bus.nwriteled, bus.nfnd, bus.nanode} !== 15'h7FFF) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected 7fff",
               {bus.naccled, bus.nwaitled, bus.nreadled, bus.nwriteled, bus.nfnd, bus.nanode});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_hex();
    bit f;
    bus.currpage = 12'h3A7;
    repeat (30) @(negedge clk);
    wait_anode(3'b011, f);
    wait_anode(3'b110, f);
    checks++;
    if (!f || bus.nfnd !== 8'b0001_1111) begin
      errors++;
      $display("[TB] FAIL hex_digit0: got %b expected 00011111", bus.nfnd);
    end
    wait_anode(3'b101, f);
    checks++;
    if (!f || bus.nfnd !== 8'b0001_0001) begin
      errors++;
      $display("[TB] FAIL hex_digit1: got %b expected 00010001", bus.nfnd);
    end
    wait_anode(3'b011, f);
    checks++;
    if (!f || bus.nfnd !== 8'b0000_1101) begin
      errors++;
      $display("[TB] FAIL hex_digit2: got %b expected 00001101", bus.nfnd);
    end
  endtask

  task automatic test_stretch();
    int n;
    bit wr_bad, acc_bad;
    bus.acctype = 3'b001;
    @(negedge clk);
    bus.acctype = 3'b100;
    checks++;
    if (bus.nreadled !== 1'b0 || bus.naccled !== 1'b0 || bus.nwriteled !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stretch_on: got rd=%b acc=%b wr=%b expected 0 0 1",
               bus.nreadled, bus.naccled, bus.nwriteled);
    end
    n = 0;
    wr_bad = 1'b0;
    acc_bad = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.nwriteled !== 1'b1) wr_bad = 1'b1;
      if (bus.nreadled === 1'b1) break;
      if (bus.naccled !== 1'b0) acc_bad = 1'b1;
    end
    checks++;
    if (n < 5 || n > 16) begin
      errors++;
      $display("[TB] FAIL stretch_len: got %0d clocks expected 5..16", n);
    end
    checks++;
    if (wr_bad || acc_bad) begin
      errors++;
      $display("[TB] FAIL stretch_side: got wr_bad=%b acc_bad=%b expected 0 0", wr_bad, acc_bad);
    end
    checks++;
    if (bus.naccled !== 1'b1 || bus.nwriteled !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stretch_off: got acc=%b wr=%b expected 1 1", bus.naccled, bus.nwriteled);
    end
  endtask

  task automatic test_decimal_point();
    bit f;
    bus.acctype = 3'b001;
    wait_anode(3'b011, f);
    wait_anode(3'b110, f);
    checks++;
    if (!f || bus.nfnd !== 8'b0001_1110) begin
      errors++;
      $display("[TB] FAIL dp_digit0: got %b expected 00011110", bus.nfnd);
    end
    wait_anode(3'b101, f);
    checks++;
    if (!f || bus.nfnd !== 8'b0001_0001) begin
      errors++;
      $display("[TB] FAIL dp_digit1: got %b expected 00010001", bus.nfnd);
    end
    bus.acctype = 3'b100;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bus.acctype = 3'b001;
    @(negedge clk);
    bus.acctype = 3'b010;
    @(negedge clk);
    bus.acctype = 3'b100;
    checks++;
    if (bus.nreadled !== 1'b0 || bus.nwriteled !== 1'b0 || bus.naccled !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overlap: got rd=%b wr=%b acc=%b expected 0 0 0",
               bus.nreadled, bus.nwriteled, bus.naccled);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (bus.nreadled !== 1'b1 || bus.nwriteled !== 1'b1 || bus.naccled !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overlap_end: got rd=%b wr=%b acc=%b expected 1 1 1",
               bus.nreadled, bus.nwriteled, bus.naccled);
    end
    bus.acctype = 3'b011;
    @(negedge clk);
    bus.acctype = 3'b111;
    checks++;
    if (bus.nreadled !== 1'b0 || bus.nwriteled !== 1'b1) begin
      errors++;
      $display("[TB] FAIL type011_read: got rd=%b wr=%b expected 0 1", bus.nreadled, bus.nwriteled);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (bus.nreadled !== 1'b1 || bus.nwriteled !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle111: got rd=%b wr=%b expected 1 1", bus.nreadled, bus.nwriteled);
    end
    bus.acctype = 3'b010;
    @(negedge clk);
    bus.acctype = 3'b100;
    checks++;
    if (bus.nwriteled !== 1'b0 || bus.nreadled !== 1'b1 || bus.naccled !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_only: got wr=%b rd=%b acc=%b expected 0 1 0",
               bus.nwriteled, bus.nreadled, bus.naccled);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_wait_latch();
    bit f;
    bus.nwait = 1'b0;
    bus.currpage = 12'h111;
    #1;
    checks++;
    if (bus.nwaitled !== 1'b1) begin
      errors++;
      $display("[TB] FAIL waitled_latency: got %b expected 1", bus.nwaitled);
    end
    @(negedge clk);
    checks++;
    if (bus.nwaitled !== 1'b0) begin
      errors++;
      $display("[TB] FAIL waitled_on: got %b expected 0", bus.nwaitled);
    end
    repeat (13) @(negedge clk);
    wait_anode(3'b110, f);
    checks++;
    if (!f || bus.nfnd !== 8'b1111_1101) begin
      errors++;
      $display("[TB] FAIL dash_digit0: got %b expected 11111101", bus.nfnd);
    end
    wait_anode(3'b101, f);
    checks++;
    if (!f || bus.nfnd !== 8'b1111_1101) begin
      errors++;
      $display("[TB] FAIL dash_digit1: got %b expected 11111101", bus.nfnd);
    end
    wait_anode(3'b011, f);
    checks++;
    if (!f || bus.nfnd !== 8'b1111_1101) begin
      errors++;
      $display("[TB] FAIL dash_digit2: got %b expected 11111101", bus.nfnd);
    end
    repeat (12) @(negedge clk);
    bus.nwait = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.nwaitled !== 1'b1) begin
      errors++;
      $display("[TB] FAIL waitled_off: got %b expected 1", bus.nwaitled);
    end
`ifndef BUBBLE_LED_DECIMAL_EN
    wait_anode(3'b011, f);
    wait_anode(3'b110, f);
    checks++;
    if (!f || bus.nfnd !== 8'b1001_1111) begin
      errors++;
      $display("[TB] FAIL latch_during_wait: got %b expected 10011111", bus.nfnd);
    end
    bus.currpage = 12'h5C4;
    wait_anode(3'b101, f);
    checks++;
    if (!f || bus.nfnd !== 8'b1001_1111) begin
      errors++;
      $display("[TB] FAIL no_tear_digit1: got %b expected 10011111", bus.nfnd);
    end
    wait_anode(3'b011, f);
    checks++;
    if (!f || bus.nfnd !== 8'b1001_1111) begin
      errors++;
      $display("[TB] FAIL no_tear_digit2: got %b expected 10011111", bus.nfnd);
    end
    wait_anode(3'b110, f);
    checks++;
    if (!f || bus.nfnd !== 8'b1001_1001) begin
      errors++;
      $display("[TB] FAIL new_digit0: got %b expected 10011001", bus.nfnd);
    end
    wait_anode(3'b101, f);
    checks++;
    if (!f || bus.nfnd !== 8'b0110_0011) begin
      errors++;
      $display("[TB] FAIL new_digit1: got %b expected 01100011", bus.nfnd);
    end
    wait_anode(3'b011, f);
    checks++;
    if (!f || bus.nfnd !== 8'b0100_1001) begin
      errors++;
      $display("[TB] FAIL new_digit2: got %b expected 01001001", bus.nfnd);
    end
`endif
  endtask

`ifdef BUBBLE_LED_DECIMAL_EN
  task automatic test_decimal();
    bit f;
    logic [7:0] exp_d [6];
    exp_d = '{8'b0001_1111, 8'b0100_1001, 8'b1001_1001,
              8'b0000_1001, 8'b0000_1001, 8'b0000_1001};
    for (int p = 0; p < 2; p++) begin
      bus.currpage = (p == 0) ? 12'd457 : 12'd1234;
      wait_anode(3'b011, f);
      wait_anode(3'b110, f);
      wait_anode(3'b011, f);
      wait_anode(3'b110, f);
      checks++;
      if (!f || bus.nfnd !== exp_d[3*p]) begin
        errors++;
        $display("[TB] FAIL dec%0d_digit0: got %b expected %b", p, bus.nfnd, exp_d[3*p]);
      end
      wait_anode(3'b101, f);
      checks++;
      if (!f || bus.nfnd !== exp_d[3*p+1]) begin
        errors++;
        $display("[TB] FAIL dec%0d_digit1: got %b expected %b", p, bus.nfnd, exp_d[3*p+1]);
      end
      wait_anode(3'b011, f);
      checks++;
      if (!f || bus.nfnd !== exp_d[3*p+2]) begin
        errors++;
        $display("[TB] FAIL dec%0d_digit2: got %b expected %b", p, bus.nfnd, exp_d[3*p+2]);
      end
    end
    // page changes between consecutive captures; only the latest may end up displayed
    bus.currpage = 12'd100;
    wait_anode(3'b011, f);
    repeat (2) @(negedge clk);
    bus.currpage = 12'd250;
    wait_anode(3'b110, f);
    wait_anode(3'b011, f);
    wait_anode(3'b110, f);
    wait_anode(3'b011, f);
    wait_anode(3'b110, f);
    wait_anode(3'b101, f);
    checks++;
    if (!f || bus.nfnd !== 8'b0100_1001) begin
      errors++;
      $display("[TB] FAIL restart_digit1: got %b expected 01001001", bus.nfnd);
    end
    wait_anode(3'b011, f);
    checks++;
    if (!f || bus.nfnd !== 8'b0010_0101) begin
      errors++;
      $display("[TB] FAIL restart_digit2: got %b expected 00100101", bus.nfnd);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
`ifdef BUBBLE_LED_DECIMAL_EN
    test_stretch();
    test_back_to_back();
    test_wait_latch();
    test_decimal();
`else
    test_hex();
    test_stretch();
    test_decimal_point();
    test_back_to_back();
    test_wait_latch();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
